// File: rtl/fetch_unit_pkg.sv
// Shared widths, defaults and the {addr, data} record carried through the
// fetch unit's prefetch queue.
package fetch_unit_pkg;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 8;

    localparam int                DEFAULT_DEPTH    = 4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetched {addr, data} entries; flush wins over push and
// a pop on an empty queue is ignored.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // Storage is cleared too so the head reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential prefetch into a small queue, one-cycle memory
// reads tracked in flight, and redirect flush/squash.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [WORD_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic              active;
    logic              rd_vld_p1;
    logic [ADDR_W-1:0] rd_addr_p1;
    logic              squash_p1;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] addr);
        return addr + 1'b1;
    endfunction

    // Issue stage: mem_rd depends on registered state only; a read that goes
    // out during a redirect cycle is squashed on return instead of blocked.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rd_vld_p1);
    assign mem_rd    = active && (occupancy < (CNT_W + 1)'(DEPTH));
    assign mem_addr  = pc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            active    <= 1'b0;
            rd_vld_p1 <= 1'b0;
            squash_p1 <= 1'b0;
        end else begin
            active    <= 1'b1;
            rd_vld_p1 <= mem_rd;
            squash_p1 <= redirect_valid;
            if (redirect_valid) begin
                pc <= redirect_addr;
            end else if (mem_rd) begin
                pc <= pc_inc(pc);
            end
        end
    end

    always_ff @(posedge clock) begin
        rd_addr_p1 <= pc;
    end

    // Return stage: data lands one cycle after issue, tagged with its address.
    assign push       = rd_vld_p1 && !squash_p1;
    assign push_entry = '{addr: rd_addr_p1, data: mem_rdata};
    assign pop        = inst_valid && inst_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head_entry),
        .count      (fifo_count)
    );

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = head_entry.data;
    assign inst_addr  = head_entry.addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for reset/backpressure, hand sequences for
// redirect, wrap and mid-run reset, and a delivery scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_addr;
    logic       inst_ready;
    logic       redirect_valid;
    logic [7:0] redirect_addr;

    int checks    = 0;
    int errors    = 0;
    int delivered = 0;

    bit         sb_en = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;
    logic [7:0] sb_dat;

    typedef struct {
        logic       rst_n;
        logic       ready;
        logic       exp_rd;
        logic [7:0] exp_maddr;
        logic       exp_valid;
        logic [7:0] exp_iaddr;
        logic       exp_zero;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    always #5 clock = ~clock;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_addr      (inst_addr),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    // Memory: memory[i] = i + 8'h10, returned one cycle after the request.
    always_ff @(posedge clock) begin
        mem_rdata <= mem_rd ? (mem_addr + 8'h10) : 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [7:0] start);
        logic [7:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back(a);
            a = a + 8'h01;
        end
    endtask

    // Every accepted instruction must be the next expected address of the stream.
    always @(negedge clock) begin
        if (sb_en && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got addr %0h, expected no delivery", inst_addr);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_dat = sb_exp + 8'h10;
                check("sb_addr", 32'(inst_addr), 32'(sb_exp));
                check("sb_data", 32'(inst_data), 32'(sb_dat));
                delivered++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut(input logic ready);
        reset_n        = 1'b0;
        inst_ready     = ready;
        redirect_valid = 1'b0;
        step();
        check("rst_mem_rd",     32'(mem_rd),     32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_addr",  32'(inst_addr),  32'd0);
        check("rst_inst_data",  32'(inst_data),  32'd0);
        reset_n = 1'b1;
        sb_restart(8'h00);
    endtask

    task automatic redirect_to(input logic [7:0] addr, input string tag);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        step();
        redirect_valid = 1'b0;
        sb_restart(addr);
        check({tag, "_r1_rd"},    32'(mem_rd),     32'd1);
        check({tag, "_r1_addr"},  32'(mem_addr),   32'(addr));
        check({tag, "_r1_valid"}, 32'(inst_valid), 32'd0);
        step();
        check({tag, "_r2_valid"}, 32'(inst_valid), 32'd0);
        step();
        check({tag, "_r3_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_r3_addr"},  32'(inst_addr),  32'(addr));
    endtask

    function automatic vec_t mk(input logic rst_n, input logic ready, input logic rd,
                                input logic [7:0] maddr, input logic vld,
                                input logic [7:0] iaddr, input logic zero);
        vec_t v;
        v.rst_n     = rst_n;
        v.ready     = ready;
        v.exp_rd    = rd;
        v.exp_maddr = maddr;
        v.exp_valid = vld;
        v.exp_iaddr = iaddr;
        v.exp_zero  = zero;
        return v;
    endfunction

    initial begin
        int         nvalid;
        int         base;
        logic [7:0] exp_d;

        reset_n        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;

        // Startup, 10 cycles of backpressure (4 reads then stall), then release.
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1);
        vecs[1]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 1);
        vecs[2]  = mk(1, 0, 1, 8'h00, 0, 8'h00, 0);
        vecs[3]  = mk(1, 0, 1, 8'h01, 0, 8'h00, 0);
        vecs[4]  = mk(1, 0, 1, 8'h02, 1, 8'h00, 0);
        vecs[5]  = mk(1, 0, 1, 8'h03, 1, 8'h00, 0);
        vecs[6]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 0);
        vecs[7]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 0);
        vecs[8]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 0);
        vecs[9]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 0);
        vecs[10] = mk(1, 0, 0, 8'h00, 1, 8'h00, 0);
        vecs[11] = mk(1, 0, 0, 8'h00, 1, 8'h00, 0);
        vecs[12] = mk(1, 1, 0, 8'h00, 1, 8'h00, 0);
        vecs[13] = mk(1, 1, 1, 8'h04, 1, 8'h01, 0);
        vecs[14] = mk(1, 1, 1, 8'h05, 1, 8'h02, 0);
        vecs[15] = mk(1, 1, 1, 8'h06, 1, 8'h03, 0);
        vecs[16] = mk(1, 1, 1, 8'h07, 1, 8'h04, 0);
        vecs[17] = mk(1, 1, 1, 8'h08, 1, 8'h05, 0);

        step();
        step();
        sb_restart(8'h00);
        sb_en = 1'b1;

        for (int k = 0; k < NV; k++) begin
            check($sformatf("vec%0d_mem_rd", k), 32'(mem_rd), 32'(vecs[k].exp_rd));
            if (vecs[k].exp_rd)
                check($sformatf("vec%0d_mem_addr", k), 32'(mem_addr), 32'(vecs[k].exp_maddr));
            check($sformatf("vec%0d_valid", k), 32'(inst_valid), 32'(vecs[k].exp_valid));
            if (vecs[k].exp_valid) begin
                exp_d = vecs[k].exp_iaddr + 8'h10;
                check($sformatf("vec%0d_iaddr", k), 32'(inst_addr), 32'(vecs[k].exp_iaddr));
                check($sformatf("vec%0d_idata", k), 32'(inst_data), 32'(exp_d));
            end
            if (vecs[k].exp_zero) begin
                check($sformatf("vec%0d_zaddr", k), 32'(inst_addr), 32'd0);
                check($sformatf("vec%0d_zdata", k), 32'(inst_data), 32'd0);
            end
            reset_n    = vecs[k].rst_n;
            inst_ready = vecs[k].ready;
            step();
        end

        // Release with ready held: latency and one-per-cycle throughput.
        reset_dut(1'b1);
        step();
        check("first_rd",     32'(mem_rd),     32'd1);
        check("first_addr",   32'(mem_addr),   32'h00);
        check("first_valid0", 32'(inst_valid), 32'd0);
        step();
        check("lat_valid0",   32'(inst_valid), 32'd0);
        step();
        check("valid_rise",      32'(inst_valid), 32'd1);
        check("valid_rise_addr", 32'(inst_addr),  32'h00);
        nvalid = 0;
        base   = delivered;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) nvalid++;
            step();
        end
        check("throughput_valid", 32'(nvalid),            32'd20);
        check("throughput_deliv", 32'(delivered - base),  32'd20);

        // Redirect with 3 queued entries and a read returning that cycle.
        reset_dut(1'b0);
        run(5);
        check("pre40_rd",    32'(mem_rd),     32'd0);
        check("pre40_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        redirect_to(8'h40, "redir40");
        run(6);

        // Redirect near the top of the address space: FE, FF, 00, 01...
        redirect_to(8'hFE, "wrap");
        base = delivered;
        run(6);
        check("wrap_deliv", 32'(delivered - base), 32'd6);

        // Back-to-back redirects: the second target wins.
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        step();
        redirect_to(8'h30, "redir30");
        run(6);

        // Reset mid-run with a read returning and the queue filling.
        reset_dut(1'b0);
        run(5);
        reset_dut(1'b1);
        step();
        check("rerst_rd",   32'(mem_rd),   32'd1);
        check("rerst_addr", 32'(mem_addr), 32'h00);
        step();
        check("rerst_valid0", 32'(inst_valid), 32'd0);
        step();
        check("rerst_valid", 32'(inst_valid), 32'd1);
        check("rerst_iaddr", 32'(inst_addr),  32'h00);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
